// File: rtl/circle_point_if.sv
// circle_point_fsm request/response bundle.
// The master side issues start/vdc_in and observes results; the slave side is
// the circle_point_fsm datapath.
interface circle_point_if;
    logic        start;
    logic [31:0] vdc_in;
    logic [31:0] result_x;
    logic [31:0] result_y;
    logic        done;
    logic        ready;

    modport master (
        output start, vdc_in,
        input  result_x, result_y, done, ready
    );

    modport slave (
        input  start, vdc_in,
        output result_x, result_y, done, ready
    );
endinterface

// File: rtl/circle_point_fsm.sv
// circle_point_fsm: maps a 16.16 Van der Corput value to (cos, sin) of 2*pi*v.
// One shared quarter-wave sine ROM (synchronous read) is sequenced by a small
// FSM; sine is read first, then cosine (= sine of phase + quarter turn).
// Optional build macro CIRCLE_INTERP_EN: linear interpolation between
// adjacent ROM entries, adding one extra ROM read per function.
module circle_point_fsm #(
    parameter int LUT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    circle_point_if.slave        bus
);

    localparam int N  = (1 << LUT_BITS) + 1;  // ROM entries, last = sin(pi/2)
    localparam int AW = LUT_BITS + 1;         // ROM address width
    localparam int S  = 14 - LUT_BITS;        // offset bits below the table index

    // Table entry i: round(sin(i*pi/(2N-2)) * 65536), elaborated once.
    function automatic int q_entry(input int i);
        real x;
        real term;
        real s;
        x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(N - 1));
        term = x;
        s    = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return $rtoi(s * 65536.0 + 0.5);
    endfunction

    logic [16:0] rom [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        localparam logic [16:0] QV = 17'(q_entry(gi));
        assign rom[gi] = QV;
    end

    // Quarter-wave argument: mirrored offset in odd quadrants, range 0..2^14.
    function automatic logic [14:0] u_of(input logic [15:0] ph);
        return ph[14] ? (15'h4000 - {1'b0, ph[13:0]}) : {1'b0, ph[13:0]};
    endfunction

    function automatic logic [AW-1:0] idx_of(input logic [15:0] ph);
        logic [14:0] u;
        u = u_of(ph);
        return AW'(u >> S);
    endfunction

    // Sign-extend the magnitude and negate in the lower half-turn.
    function automatic logic [31:0] apply_sign(input logic neg, input logic [16:0] mag);
        logic [31:0] m;
        m = {15'b0, mag};
        return neg ? (~m + 32'd1) : m;
    endfunction

`ifdef CIRCLE_INTERP_EN
    localparam int PW = S + 17;

    function automatic logic [S-1:0] frac_of(input logic [15:0] ph);
        logic [14:0] u;
        u = u_of(ph);
        return u[S-1:0];
    endfunction

    // Table is monotonic over the quarter wave, so hi - lo never goes negative.
    function automatic logic [16:0] interp(input logic [16:0] lo, input logic [16:0] hi,
                                           input logic [S-1:0] fr);
        logic [PW-1:0] prod;
        prod = PW'(hi - lo) * PW'(fr);
        return lo + 17'(prod >> S);
    endfunction

    // Upper neighbour, held at the last entry (frac is zero there anyway).
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
        return (i == AW'(N - 1)) ? i : i + AW'(1);
    endfunction
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIN_A = 3'd1,
        SIN_B = 3'd2,
        COS_A = 3'd3,
        COS_B = 3'd4,
        LAST  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     p_q;
    logic [16:0]     rom_q;
    logic [16:0]     sin_mag_q;
    logic [31:0]     res_x_q, res_y_q;
    logic [AW-1:0]   rom_addr;
    logic [15:0]     c_phase;
    logic [AW-1:0]   s_idx, c_idx;
    logic [16:0]     cos_mag;
`ifdef CIRCLE_INTERP_EN
    logic [16:0]     lo_q;
`endif

    assign c_phase = p_q + 16'h4000;
    assign s_idx   = idx_of(p_q);
    assign c_idx   = idx_of(c_phase);

`ifdef CIRCLE_INTERP_EN
    assign cos_mag = interp(lo_q, rom_q, frac_of(c_phase));
`else
    assign cos_mag = rom_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and ROM address; start only counts while idle.
    always_comb begin
        state_d  = state_q;
        rom_addr = '0;
        case (state_q)
            IDLE: if (bus.start) state_d = SIN_A;
`ifdef CIRCLE_INTERP_EN
            SIN_A: begin rom_addr = s_idx;           state_d = SIN_B; end
            SIN_B: begin rom_addr = next_idx(s_idx); state_d = COS_A; end
            COS_A: begin rom_addr = c_idx;           state_d = COS_B; end
            COS_B: begin rom_addr = next_idx(c_idx); state_d = LAST;  end
`else
            SIN_A: begin rom_addr = s_idx; state_d = COS_A; end
            COS_A: begin rom_addr = c_idx; state_d = LAST;  end
`endif
            LAST:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ROM read, phase latch, sine capture and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q     <= '0;
            p_q       <= '0;
            sin_mag_q <= '0;
            res_x_q   <= '0;
            res_y_q   <= '0;
`ifdef CIRCLE_INTERP_EN
            lo_q      <= '0;
`endif
        end else begin
            rom_q <= rom[rom_addr];
            if (state_q == IDLE && bus.start) p_q <= bus.vdc_in[15:0];
            case (state_q)
`ifdef CIRCLE_INTERP_EN
                SIN_B: lo_q      <= rom_q;
                COS_A: sin_mag_q <= interp(lo_q, rom_q, frac_of(p_q));
                COS_B: lo_q      <= rom_q;
`else
                COS_A: sin_mag_q <= rom_q;
`endif
                LAST: begin
                    res_x_q <= apply_sign(c_phase[15], cos_mag);
                    res_y_q <= apply_sign(p_q[15], sin_mag_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.result_x = res_x_q;
    assign bus.result_y = res_y_q;
    assign bus.done     = (state_q == DONE);
    assign bus.ready    = (state_q == IDLE);

endmodule

// File: tb/tb_circle_point_fsm.sv
// Directed bench for circle_point_fsm: table of vectors plus handshake and
// mid-operation reset sequences. Latency follows the CIRCLE_INTERP_EN build.
`timescale 1ns/1ps
module tb_circle_point_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circle_point_if bus();

    circle_point_fsm #(.LUT_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef CIRCLE_INTERP_EN
    localparam int LAT = 5;
    localparam logic [31:0] Y_0020 = 32'd201;
`else
    localparam int LAT = 3;
    localparam logic [31:0] Y_0020 = 32'd0;
`endif

    typedef struct {
        logic [31:0] vdc;
        logic [31:0] ex;
        logic [31:0] ey;
        string       name;
    } vec_t;

    vec_t vecs[7];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full request with cycle-exact done/ready checks.
    task automatic run(input logic [31:0] vdc, input logic [31:0] ex, input logic [31:0] ey,
                       input string name);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.vdc_in = vdc;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.vdc_in = 32'hDEAD_BEEF;
        check({name, ".ready_low"}, 32'(bus.ready), 32'd0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s.done_e%0d", name, k), 32'(bus.done), 32'(k == LAT));
        end
        check({name, ".ready_back"}, 32'(bus.ready), 32'd1);
        check({name, ".x"}, bus.result_x, ex);
        check({name, ".y"}, bus.result_y, ey);
    endtask

    initial begin
        int dones;
        vecs[0] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, "q0"};
        vecs[1] = '{32'h0000_4000, 32'h0000_0000, 32'h0001_0000, "q1"};
        vecs[2] = '{32'h0000_8000, 32'hFFFF_0000, 32'h0000_0000, "q2"};
        vecs[3] = '{32'h0000_C000, 32'h0000_0000, 32'hFFFF_0000, "q3"};
        vecs[4] = '{32'h0000_2000, 32'h0000_B505, 32'h0000_B505, "eighth"};
        vecs[5] = '{32'h0001_2000, 32'h0000_B505, 32'h0000_B505, "eighth_wrap"};
        vecs[6] = '{32'h0000_0020, 32'h0000_FFFF, Y_0020,        "frac32"};

        bus.start  = 1'b0;
        bus.vdc_in = 32'h0;

        // Reset state, both during and after reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst.x",     bus.result_x, 32'h0);
        check("rst.y",     bus.result_y, 32'h0);
        check("rst.done",  32'(bus.done), 32'd0);
        check("rst.ready", 32'(bus.ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.ready", 32'(bus.ready), 32'd1);
        check("rel.done",  32'(bus.done), 32'd0);

        for (int i = 0; i < 7; i++) run(vecs[i].vdc, vecs[i].ex, vecs[i].ey, vecs[i].name);

        // Extra start pulses in SIN_A and in DONE are ignored.
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.vdc_in = 32'h0000_2000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.vdc_in = 32'h0000_8000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (bus.done) dones++;
        for (int k = 2; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("hs.done_at_lat", 32'(bus.done), 32'd1);
        bus.start = 1'b1; bus.vdc_in = 32'h0000_8000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("hs.ready_after_done", 32'(bus.ready), 32'd1);
        for (int k = 0; k < LAT + 3; k++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        check("hs.single_done", 32'(dones), 32'd1);
        check("hs.still_idle",  32'(bus.ready), 32'd1);
        check("hs.x_kept",      bus.result_x, 32'h0000_B505);
        check("hs.y_kept",      bus.result_y, 32'h0000_B505);
        run(32'h0000_8000, 32'hFFFF_0000, 32'h0, "hs.next");

        // Reset asserted while in COS_A.
        @(negedge clk);
        bus.start = 1'b1; bus.vdc_in = 32'h0000_4000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat ((LAT == 5) ? 2 : 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid.x",     bus.result_x, 32'h0);
        check("mid.y",     bus.result_y, 32'h0);
        check("mid.ready", 32'(bus.ready), 32'd1);
        dones = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("mid.no_done", 32'(dones), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(32'h0000_C000, 32'h0, 32'hFFFF_0000, "mid.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
